mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Controller that drives the select of the 16-way, 8-bit operand mux in the CNN datapath.
- Streams a configurable window of mux inputs (base index and length, wrapping modulo 16) to a downstream consumer, repeated for a programmed number of passes.
- Registers the mux output into a single-entry output stage with a valid/ready handshake, so the MAC/consumer can apply backpressure.
- Sits between the buffer mux and the PE input; started by the layer control FSM.

Parameters:
- DATA_W, 8, width of mux data in/out.
- SEL_W, 4, mux select width; depth = 2**SEL_W = 16.
- PASS_W, 8, width of pass-count configuration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a job; sampled only in IDLE.
- base  input  SEL_W  first mux index of the window; latched on accepted start.
- len  input  SEL_W+1  window length, 0..16; latched on accepted start.
- passes  input  PASS_W  number of window repetitions; latched on accepted start.
- sel  output  SEL_W  select to the mux; combinationally equal to the internal pointer.
- mux_data  input  DATA_W  mux output for the current sel.
- out_data  output  DATA_W  registered sample.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_last  output  1  beat is the last of its pass; qualified by out_valid.
- out_final  output  1  beat is the last of the whole job; qualified by out_valid.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at job completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; ptr, cnt, pass_cnt = 0.
  - sel = 0; out_data = 0.
  - out_valid, out_last, out_final, busy, done = 0.
- Reset asserted mid-job aborts immediately. There is no done pulse and any pending beat is dropped.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with len != 0 and passes != 0: latch base, len and passes; ptr <= base; cnt <= 0; pass_cnt <= 0; go to RUN.
  - start with len == 0 or passes == 0: done pulses the next cycle; stay in IDLE; no beats produced.
- Load condition: load = !out_valid || out_ready. A beat is registered only on load.
- RUN, on each load:
  - out_data <= mux_data; out_valid <= 1.
  - out_last <= (cnt == len-1).
  - out_final <= (cnt == len-1) && (pass_cnt == passes-1).
  - If cnt == len-1: ptr <= base, cnt <= 0, pass_cnt <= pass_cnt+1. If this was the final beat, go to DRAIN.
  - Otherwise: ptr <= (ptr+1) mod 16 (natural wrap 15 -> 0); cnt <= cnt+1.
- RUN without load: ptr, cnt, pass_cnt and the output register all hold.
- RUN with out_valid && out_ready and no new load is impossible, since load is true whenever out_ready is high.
- DRAIN:
  - On out_valid && out_ready: out_valid <= 0, out_last <= 0, out_final <= 0, done <= 1 for one cycle; go to IDLE.
  - done and the state return to IDLE occur in the same cycle.
- start while busy is ignored; configuration inputs are don't-care outside an accepted start.
- Latency:
  - start sampled at edge N puts state in RUN after N. The first beat (mux input base) is valid after edge N+1.
  - With out_ready held high, throughput is 1 beat/cycle and total beats = len*passes.
  - done asserts the cycle after the final beat handshake.
- Back-to-back jobs: start is accepted the cycle done is high, because the state is already IDLE.
- len = 16: full sweep base..base+15 mod 16, every index exactly once per pass.
- sel always equals the pointer of the next beat to be loaded. sel is stable while stalled.

Test Plan:
- Basic stream:
  - Stimulus: mux input i = 8'h10+i; base=2, len=3, passes=1; out_ready=1.
  - Required: beats 12,13,14; out_last and out_final on 14; done 1 cycle after; busy low afterwards.
- Wrap-around with repeats:
  - Stimulus: base=14, len=4, passes=2.
  - Required: 1E,1F,10,11,1E,1F,10,11; out_last on both 11s; out_final only on the second 11.
- Backpressure:
  - Stimulus: as in the basic stream, but out_ready low for 3 cycles after the first valid beat.
  - Required: out_data holds 12 and sel holds 3 throughout the stall; no beat lost or duplicated; sequence resumes 13,14.
- Degenerate and ignored starts:
  - Stimulus: len=0 with passes=5, then len=4 with passes=0.
  - Required: each gives a done pulse one cycle after start, with out_valid never high.
  - Stimulus: start pulsed mid-job.
  - Required: the second start is ignored.
- Full sweep and back-to-back:
  - Stimulus: base=0, len=16, passes=1; start asserted again in the done cycle with base=5, len=1, passes=3.
  - Required: first job yields 10..1F; second job yields 15,15,15, each beat with out_last and only the third with out_final.
- Reset mid-operation:
  - Stimulus: assert rst after 2 beats of a len=8 job.
  - Required: next cycle out_valid=0, busy=0, sel=0, done=0; a new start then runs cleanly from its base.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives the select of the 16-way operand mux in the CNN
// datapath. It streams a window of mux inputs (base, len, wrapping modulo 16)
// for a programmed number of passes. Each selected sample is registered into
// a single-entry valid/ready output stage, so the consumer can stall the stream.
module mux_sel_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  base,
    input  logic [SEL_W:0]    len,
    input  logic [PASS_W-1:0] passes,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_final,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [SEL_W-1:0]  PTR_ONE  = 1;
    localparam logic [SEL_W:0]    CNT_ONE  = 1;
    localparam logic [PASS_W-1:0] PASS_ONE = 1;

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W:0]    cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic [SEL_W-1:0]  base_q;
    logic [SEL_W:0]    len_q;
    logic [PASS_W-1:0] passes_q;

    logic load;
    logic pass_end;
    logic job_end;

    // The output stage takes a new beat whenever it is empty or being drained.
    assign load     = !out_valid || out_ready;
    assign pass_end = (cnt == len_q - CNT_ONE);
    assign job_end  = pass_end && (pass_cnt == passes_q - PASS_ONE);

    // The pointer always names the next beat to be loaded, so it drives the mux directly.
    assign sel  = ptr;
    assign busy = (state != IDLE);

    // Job FSM: window pointer, pass counting and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            pass_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_final <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0 && passes != '0) begin
                            base_q   <= base;
                            len_q    <= len;
                            passes_q <= passes;
                            ptr      <= base;
                            cnt      <= '0;
                            pass_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            // Empty job: complete immediately with no beats.
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        out_data  <= mux_data;
                        out_valid <= 1'b1;
                        out_last  <= pass_end;
                        out_final <= job_end;
                        if (pass_end) begin
                            ptr      <= base_q;
                            cnt      <= '0;
                            pass_cnt <= pass_cnt + PASS_ONE;
                            if (job_end) begin
                                state <= DRAIN;
                            end
                        end else begin
                            ptr <= ptr + PTR_ONE;
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the final beat to be taken, then signal completion.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_final <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Testbench for mux_sel_sequencer: table-driven jobs plus hand-written
// sequences for backpressure, ignored start, back-to-back jobs and reset.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base = '0;
    logic [4:0] len = '0;
    logic [7:0] passes = '0;
    logic [3:0] sel;
    logic [7:0] mux_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       out_final;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Mux model: input i carries 8'h10 + i.
    assign mux_data = 8'h10 + {4'h0, sel};

    always #5 clk = ~clk;

    mux_sel_sequencer #(.DATA_W(8), .SEL_W(4), .PASS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .passes    (passes),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_final (out_final),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        string       name;
        logic [3:0]  base;
        logic [4:0]  len;
        logic [7:0]  passes;
        int          beats;
        logic [127:0] seq;   // expected data of one pass, beat k in bits [8k +: 8]
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [3:0] b, input logic [4:0] l, input logic [7:0] p);
        start  = 1'b1;
        base   = b;
        len    = l;
        passes = p;
        tick();
        start  = 1'b0;
    endtask

    task automatic chk_beat(input string nm, input logic [7:0] d, input logic l, input logic f);
        chk({nm, ".valid"}, 32'(out_valid), 1);
        chk({nm, ".data"},  32'(out_data),  32'(d));
        chk({nm, ".last"},  32'(out_last),  32'(l));
        chk({nm, ".final"}, 32'(out_final), 32'(f));
    endtask

    task automatic run_vec(input vec_t v);
        int idx;
        out_ready = 1'b1;
        pulse_start(v.base, v.len, v.passes);
        if (v.beats == 0) begin
            chk({v.name, ".done"},  32'(done), 1);
            chk({v.name, ".valid"}, 32'(out_valid), 0);
            chk({v.name, ".busy"},  32'(busy), 0);
            tick();
            chk({v.name, ".done_end"}, 32'(done), 0);
            chk({v.name, ".valid2"},   32'(out_valid), 0);
        end else begin
            chk({v.name, ".busy"},  32'(busy), 1);
            chk({v.name, ".sel0"},  32'(sel), 32'(v.base));
            chk({v.name, ".nobeat"}, 32'(out_valid), 0);
            for (int k = 0; k < v.beats; k++) begin
                tick();
                idx = k % int'(v.len);
                chk_beat($sformatf("%s.b%0d", v.name, k), v.seq[idx*8 +: 8],
                         idx == int'(v.len) - 1, k == v.beats - 1);
                chk({v.name, ".nodone"}, 32'(done), 0);
            end
            tick();
            chk({v.name, ".done"},  32'(done), 1);
            chk({v.name, ".valid"}, 32'(out_valid), 0);
            chk({v.name, ".busy"},  32'(busy), 0);
            tick();
            chk({v.name, ".done_end"}, 32'(done), 0);
        end
    endtask

    initial begin
        vecs[0] = '{"basic",  4'd2,  5'd3,  8'd1, 3,  128'h141312};
        vecs[1] = '{"wrap",   4'd14, 5'd4,  8'd2, 8,  128'h11101F1E};
        vecs[2] = '{"sweep",  4'd0,  5'd16, 8'd1, 16, 128'h1F1E1D1C1B1A19181716151413121110};
        vecs[3] = '{"single", 4'd15, 5'd1,  8'd2, 2,  128'h1F};
        vecs[4] = '{"len0",   4'd3,  5'd0,  8'd5, 0,  128'h0};
        vecs[5] = '{"pass0",  4'd3,  5'd4,  8'd0, 0,  128'h0};

        // Reset state
        tick();
        tick();
        chk("rst.sel",   32'(sel), 0);
        chk("rst.data",  32'(out_data), 0);
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.last",  32'(out_last), 0);
        chk("rst.final", 32'(out_final), 0);
        chk("rst.busy",  32'(busy), 0);
        chk("rst.done",  32'(done), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: stall three cycles on the first beat
        pulse_start(4'd2, 5'd3, 8'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat("bp.hold", 8'h12, 1'b0, 1'b0);
            chk("bp.sel", 32'(sel), 3);
        end
        out_ready = 1'b1;
        tick();
        chk_beat("bp.b1", 8'h13, 1'b0, 1'b0);
        chk("bp.sel1", 32'(sel), 4);
        tick();
        chk_beat("bp.b2", 8'h14, 1'b1, 1'b1);
        tick();
        chk("bp.done", 32'(done), 1);
        chk("bp.valid", 32'(out_valid), 0);
        tick();

        // Start pulsed mid-job is ignored
        pulse_start(4'd2, 5'd3, 8'd1);
        tick();
        chk_beat("mid.b0", 8'h12, 1'b0, 1'b0);
        start = 1'b1; base = 4'd9; len = 5'd2; passes = 8'd1;
        tick();
        start = 1'b0;
        chk_beat("mid.b1", 8'h13, 1'b0, 1'b0);
        tick();
        chk_beat("mid.b2", 8'h14, 1'b1, 1'b1);
        tick();
        chk("mid.done", 32'(done), 1);
        tick();
        chk("mid.idle_valid", 32'(out_valid), 0);
        chk("mid.idle_busy",  32'(busy), 0);

        // Full sweep followed by a start in the done cycle
        pulse_start(4'd0, 5'd16, 8'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_beat($sformatf("b2b.a%0d", k), 8'h10 + 8'(k), k == 15, k == 15);
        end
        tick();
        chk("b2b.done", 32'(done), 1);
        pulse_start(4'd5, 5'd1, 8'd3);
        chk("b2b.done_end", 32'(done), 0);
        chk("b2b.busy", 32'(busy), 1);
        chk("b2b.sel",  32'(sel), 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat($sformatf("b2b.c%0d", k), 8'h15, 1'b1, k == 2);
        end
        tick();
        chk("b2b.done2", 32'(done), 1);
        tick();

        // Reset after two beats of a len=8 job
        pulse_start(4'd0, 5'd8, 8'd1);
        tick();
        chk_beat("rmid.b0", 8'h10, 1'b0, 1'b0);
        tick();
        chk_beat("rmid.b1", 8'h11, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid.valid", 32'(out_valid), 0);
        chk("rmid.busy",  32'(busy), 0);
        chk("rmid.sel",   32'(sel), 0);
        chk("rmid.done",  32'(done), 0);
        tick();
        chk("rmid.nodone", 32'(done), 0);
        pulse_start(4'd6, 5'd2, 8'd1);
        tick();
        chk_beat("rmid.n0", 8'h16, 1'b0, 1'b0);
        tick();
        chk_beat("rmid.n1", 8'h17, 1'b1, 1'b1);
        tick();
        chk("rmid.ndone", 32'(done), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
